// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the CPU sequencer.
//   state_t  : sequencer states (FETCH, EXEC1, EXEC2, HALTED, FAULT)
//   opcode_t : 6-bit primary opcode, with OP_* constants
//   func_t   : 6-bit SPECIAL function field, with FUNC_* constants
//   ctrl_t   : bundle of the nine datapath control strobes
//   is_legal : true for the supported instruction subset
package codes;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC1  = 3'd1,
    EXEC2  = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] func_t;

  localparam opcode_t OP_SPECIAL = 6'h00;
  localparam opcode_t OP_ADDIU   = 6'h09;
  localparam opcode_t OP_LW      = 6'h23;
  localparam opcode_t OP_SW      = 6'h2B;

  localparam func_t FUNC_JR   = 6'h08;
  localparam func_t FUNC_ADDU = 6'h21;

  typedef struct packed {
    logic pc_wen;
    logic ir_wen;
    logic ram_wen;
    logic ram_rds;
    logic reg_wen;
    logic src_b_sel;
    logic ram_a_sel;
    logic reg_wd_sel;
    logic reg_a3_sel;
  } ctrl_t;

  function automatic logic is_legal(opcode_t op, func_t fn);
    case (op)
      OP_LW, OP_SW, OP_ADDIU: is_legal = 1'b1;
      OP_SPECIAL:             is_legal = (fn == FUNC_ADDU) || (fn == FUNC_JR);
      default:                is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer and the datapath.
//   master : the sequencer (consumes instruction fields / memory status,
//            drives state, status and control strobes)
//   slave  : the datapath side (the mirror image)
interface cpu_sequencer_if;
  import codes::*;

  opcode_t opcode_i;
  func_t   function_i;
  logic    waitrequest_i;
  logic    jr_zero_i;

  state_t  state_o;
  logic    active_o;
  logic    fault_o;
  logic    pc_wen_o;
  logic    ir_wen_o;
  logic    ram_wen_o;
  logic    ram_rds_o;
  logic    reg_wen_o;
  logic    src_b_sel_o;
  logic    ram_a_sel_o;
  logic    reg_wd_sel_o;
  logic    reg_a3_sel_o;

  modport master (
    input  opcode_i, function_i, waitrequest_i, jr_zero_i,
    output state_o, active_o, fault_o,
           pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o,
           src_b_sel_o, ram_a_sel_o, reg_wd_sel_o, reg_a3_sel_o
  );

  modport slave (
    output opcode_i, function_i, waitrequest_i, jr_zero_i,
    input  state_o, active_o, fault_o,
           pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o,
           src_b_sel_o, ram_a_sel_o, reg_wd_sel_o, reg_a3_sel_o
  );

endinterface

// File: rtl/cpu_sequencer_decode.sv
// Combinational control decode for the CPU sequencer.
//   state_i    : current sequencer state
//   opcode_i   : primary opcode
//   function_i : SPECIAL function field
//   first_i    : first cycle of the current state (stall counter is 0)
//   stall_i    : the current access state is waiting on memory
//   ctrl_o     : datapath control strobes
module cpu_decode
  import codes::*;
(
  input  state_t  state_i,
  input  opcode_t opcode_i,
  input  func_t   function_i,
  input  logic    first_i,
  input  logic    stall_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: ctrl_o.ram_rds = 1'b1;

      EXEC1: begin
        // IR latches once; later stalled EXEC1 cycles must not reload it.
        // An illegal opcode gets only this strobe before heading to FAULT.
        ctrl_o.ir_wen = first_i;
        if (opcode_i == OP_LW) begin
          ctrl_o.ram_rds   = 1'b1;
          ctrl_o.src_b_sel = 1'b1;
          ctrl_o.ram_a_sel = 1'b1;
        end
      end

      EXEC2: begin
        case (opcode_i)
          OP_SW: begin
            ctrl_o.ram_wen   = 1'b1;
            ctrl_o.src_b_sel = 1'b1;
            ctrl_o.ram_a_sel = 1'b1;
            ctrl_o.pc_wen    = !stall_i;
          end
          OP_LW: begin
            ctrl_o.reg_wen = 1'b1;
            ctrl_o.pc_wen  = 1'b1;
          end
          OP_ADDIU: begin
            ctrl_o.reg_wen    = 1'b1;
            ctrl_o.src_b_sel  = 1'b1;
            ctrl_o.reg_wd_sel = 1'b1;
            ctrl_o.pc_wen     = 1'b1;
          end
          OP_SPECIAL: begin
            if (function_i == FUNC_ADDU) begin
              ctrl_o.reg_wen    = 1'b1;
              ctrl_o.reg_wd_sel = 1'b1;
              ctrl_o.reg_a3_sel = 1'b1;
              ctrl_o.pc_wen     = 1'b1;
            end else if (function_i == FUNC_JR) begin
              ctrl_o.pc_wen = 1'b1;
            end
          end
          default: ;
        endcase
      end

      default: ;  // HALTED, FAULT: everything off
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH -> EXEC1 -> EXEC2 with memory
// stalls, a stall-timeout watchdog, and absorbing HALTED/FAULT states.
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : cpu_sequencer_if.master (instruction fields, memory status,
//             state/status outputs and control strobes)
// Parameters: WAIT_W (stall counter width), WAIT_LIMIT (stall cycles that
// trigger FAULT, 0 disables).
module cpu_sequencer
  import codes::*;
#(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 200
) (
  input  logic              clk_i,
  input  logic              reset_i,
  cpu_sequencer_if.master   bus
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              access;
  logic              stall;
  logic              timeout;
  ctrl_t             ctrl;

  // Only memory-access cycles honour waitrequest; elsewhere it is ignored.
  always_comb begin
    access = 1'b0;
    case (state_q)
      FETCH:   access = 1'b1;
      EXEC1:   access = (bus.opcode_i == OP_LW);
      EXEC2:   access = (bus.opcode_i == OP_SW);
      default: access = 1'b0;
    endcase
  end

  assign stall   = access && bus.waitrequest_i;
  // Counter value k means k stalled cycles already spent in this state.
  assign timeout = (WAIT_LIMIT != 0) && (int'(wait_q) == WAIT_LIMIT - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (stall) state_d = timeout ? FAULT : FETCH;
        else       state_d = EXEC1;
      end
      EXEC1: begin
        if (!is_legal(bus.opcode_i, bus.function_i)) state_d = FAULT;
        else if (stall) state_d = timeout ? FAULT : EXEC1;
        else            state_d = EXEC2;
      end
      EXEC2: begin
        if (stall) state_d = timeout ? FAULT : EXEC2;
        else if (bus.opcode_i == OP_SPECIAL && bus.function_i == FUNC_JR &&
                 bus.jr_zero_i)
          state_d = HALTED;
        else
          state_d = FETCH;
      end
      HALTED:  state_d = HALTED;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)           wait_d = '0;
    else if (stall && wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  cpu_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (bus.opcode_i),
    .function_i (bus.function_i),
    .first_i    (wait_q == '0),
    .stall_i    (stall),
    .ctrl_o     (ctrl)
  );

  assign bus.state_o      = state_q;
  assign bus.active_o     = (state_q != HALTED) && (state_q != FAULT);
  assign bus.fault_o      = (state_q == FAULT);
  assign bus.pc_wen_o     = ctrl.pc_wen;
  assign bus.ir_wen_o     = ctrl.ir_wen;
  assign bus.ram_wen_o    = ctrl.ram_wen;
  assign bus.ram_rds_o    = ctrl.ram_rds;
  assign bus.reg_wen_o    = ctrl.reg_wen;
  assign bus.src_b_sel_o  = ctrl.src_b_sel;
  assign bus.ram_a_sel_o  = ctrl.ram_a_sel;
  assign bus.reg_wd_sel_o = ctrl.reg_wd_sel;
  assign bus.reg_a3_sel_o = ctrl.reg_a3_sel;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter WAIT_W, default 8: width of the stall counter.
REQ-002 Parameter WAIT_LIMIT, default 200: consecutive stall cycles that cause FAULT; 0 disables the timeout.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state changes on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 opcode_i  in  6 and function_i  in  6: instruction fields, valid in EXEC1 and EXEC2.
REQ-007 waitrequest_i  in  1  memory busy; the current RAM access has not completed.
REQ-008 jr_zero_i  in  1  the jump target register equals 0.
REQ-009 state_o  out  state_t  current state.
REQ-010 active_o  out  1  high unless HALTED or FAULT.
REQ-011 fault_o  out  1  high in FAULT.
REQ-012 Control outputs, all out, 1 bit: pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o, src_b_sel_o, ram_a_sel_o, reg_wd_sel_o, reg_a3_sel_o.

Function
REQ-013 States SHALL be FETCH, EXEC1, EXEC2, HALTED and FAULT; the block owns the state register.
REQ-014 Every control output SHALL be 0 unless a rule below asserts it; no X values are driven.
REQ-015 FETCH: ram_rds_o=1; advance to EXEC1 when waitrequest_i=0, else hold.
REQ-016 EXEC1, all instructions: ir_wen_o=1 only in the first EXEC1 cycle, i.e. when the stall counter is 0.
REQ-017 EXEC1, LW: ram_rds_o=1, src_b_sel_o=1 and ram_a_sel_o=1; hold while waitrequest_i=1.
REQ-018 EXEC1, other legal opcodes: advance to EXEC2 next cycle.
REQ-019 Legal instructions are LW, SW, ADDIU, and SPECIAL with function ADDU or JR.
REQ-020 An illegal instruction in EXEC1 SHALL drive all outputs except ir_wen_o to 0 and go to FAULT.
REQ-021 EXEC2: pc_wen_o=1 in the completing cycle only, then go to FETCH.
REQ-022 EXEC2, SW: ram_wen_o=1, src_b_sel_o=1 and ram_a_sel_o=1 while the write is pending; completion waits for waitrequest_i=0.
REQ-023 EXEC2, LW: reg_wen_o=1 with reg_wd_sel_o=0 and reg_a3_sel_o=0.
REQ-024 EXEC2, ADDIU: reg_wen_o=1, src_b_sel_o=1 and reg_wd_sel_o=1.
REQ-025 EXEC2, ADDU: reg_wen_o=1, reg_wd_sel_o=1 and reg_a3_sel_o=1.
REQ-026 EXEC2, JR: pc_wen_o=1; if jr_zero_i=1, go to HALTED instead of FETCH.
REQ-027 Stall rule: while waitrequest_i=1 during an access state, pc_wen_o, ir_wen_o (after the first cycle) and reg_wen_o SHALL be 0.
REQ-028 Stall rule: while stalled, the access strobes ram_rds_o and ram_wen_o and their address selects SHALL stay asserted.
REQ-029 The stall counter SHALL increment on each stalled cycle, saturate at 2^WAIT_W-1, and clear on any state change.
REQ-030 When WAIT_LIMIT is nonzero and the counter reaches WAIT_LIMIT-1 while still stalled, the next state SHALL be FAULT.
REQ-031 waitrequest_i SHALL be ignored in non-access cycles, i.e. EXEC1 for non-LW and EXEC2 for non-SW.
REQ-032 HALTED and FAULT are absorbing until reset; all control outputs are 0 in both.

Reset
REQ-033 While reset_i=1 at a clock edge, the next state SHALL be FETCH and the stall counter 0; reset overrides any stall, halt or fault.
REQ-034 After reset, active_o=1, fault_o=0, ram_rds_o=1 and all other control outputs are 0.

Structure
REQ-035 state_t (FETCH, EXEC1, EXEC2, HALTED, FAULT), opcode_t, func_t and the OP_*/FUNC_* constants SHALL live in package codes.
REQ-036 The design SHALL be a registered state/counter process plus a combinational decode process.
REQ-037 The decode SHALL be one sub-module, cpu_decode, mapping (state, opcode, function, stall) to the control outputs.

Verification
REQ-038 Reset, then ADDIU with waitrequest_i=0 -> states FETCH, EXEC1, EXEC2, FETCH; one pc_wen_o pulse; reg_wen_o=1 in EXEC2 only.
REQ-039 LW with waitrequest_i=1 for 3 cycles in EXEC1 -> EXEC1 lasts 4 cycles; ir_wen_o high in the first cycle only; reg_wen_o=1 in EXEC2.
REQ-040 SW with waitrequest_i=1 for 2 cycles in EXEC2 -> ram_wen_o high for 3 cycles; pc_wen_o high in the third cycle only.
REQ-041 JR with jr_zero_i=1 -> pc_wen_o pulse, then HALTED, active_o=0 and all outputs 0 for 10 cycles or more.
REQ-042 Illegal opcode 6'h3F -> FAULT after EXEC1; fault_o=1. Separately, WAIT_LIMIT=4 with waitrequest_i held at 1 in FETCH -> FAULT on the 5th edge.
REQ-043 reset_i=1 during a stalled EXEC2 SW -> FETCH next cycle; ram_wen_o=0 and the stall counter 0.
